// File: rtl/ddio_out_mc.sv
// ddio_out_mc: multi-channel DDR output register with pipeline, output enable, clear/set and pattern modes
// Ports:
//   clk      - system clock, both edges used
//   aclr     - asynchronous clear, active-high
//   clk_en   - posedge pipeline advance enable
//   datain_h - posedge word per channel, channel c at [c*WIDTH +: WIDTH]
//   datain_l - negedge word per channel, same packing
//   oe       - per-channel output enable
//   sclr     - synchronous clear to 0 (wins over sset)
//   sset     - synchronous set to all-1
//   mode     - 0 DDR, 1 SDR, 2 training, 3 walking-one
//   dataout  - DDR pin data: high-phase word while clk=1, low-phase word while clk=0
//   oe_out   - output enable aligned with dataout
module ddio_out_mc #(
   parameter int              WIDTH     = 8,
   parameter int              NCH       = 3,
   parameter int              PIPE      = 1,
   parameter logic [WIDTH-1:0] TRAIN_PAT = 8'hA5
) (
   input  logic                 clk,
   input  logic                 aclr,
   input  logic                 clk_en,
   input  logic [NCH*WIDTH-1:0] datain_h,
   input  logic [NCH*WIDTH-1:0] datain_l,
   input  logic [NCH-1:0]       oe,
   input  logic                 sclr,
   input  logic                 sset,
   input  logic [1:0]           mode,
   output logic [NCH*WIDTH-1:0] dataout,
   output logic [NCH-1:0]       oe_out
);
   localparam int W = NCH*WIDTH;
   if (PIPE < 1 || PIPE > 4) begin : g_bad_pipe
      $error("ddio_out_mc: PIPE must be in 1..4");
   end
   logic [W-1:0]     h_pipe  [PIPE];
   logic [W-1:0]     l_pipe  [PIPE];
   logic [NCH-1:0]   oe_pipe [PIPE];
   logic [W-1:0]     h1, l1, out_l;
   logic [WIDTH-1:0] walk, walk_nx;
   logic [1:0]       prev_mode;
   // entering mode 3 restarts the walk at bit0, staying in it rotates left
   assign walk_nx = (prev_mode == 2'd3) ? ((walk << 1) | (walk >> (WIDTH-1))) : WIDTH'(1);
   always_comb begin
      h1 = sclr ? '0 : sset ? '1 : (mode == 2'd0 || mode == 2'd1) ? datain_h :
           (mode == 2'd2) ? {NCH{TRAIN_PAT}} : {NCH{walk_nx}};
      l1 = sclr ? '0 : sset ? '1 : (mode == 2'd0) ? datain_l : (mode == 2'd1) ? datain_h :
           (mode == 2'd2) ? {NCH{~TRAIN_PAT}} : {NCH{walk_nx}};
   end
   always_ff @(posedge clk or posedge aclr)
      if (aclr) begin
         for (int i = 0; i < PIPE; i++) begin
            h_pipe[i]  <= '0;
            l_pipe[i]  <= '0;
            oe_pipe[i] <= '0;
         end
         walk      <= '0;
         prev_mode <= '0;
      end else if (clk_en) begin
         h_pipe[0]  <= h1;
         l_pipe[0]  <= l1;
         oe_pipe[0] <= oe;
         for (int i = 1; i < PIPE; i++) begin
            h_pipe[i]  <= h_pipe[i-1];
            l_pipe[i]  <= l_pipe[i-1];
            oe_pipe[i] <= oe_pipe[i-1];
         end
         prev_mode <= mode;
         if (mode == 2'd3) walk <= walk_nx;
      end
   // low-phase word is retimed on the falling edge so it is stable for the whole low phase
   always_ff @(negedge clk or posedge aclr)
      if (aclr) out_l <= '0;
      else      out_l <= l_pipe[PIPE-1];
   assign oe_out = oe_pipe[PIPE-1];
   for (genvar c = 0; c < NCH; c++) begin : g_ch
      assign dataout[c*WIDTH +: WIDTH] = oe_out[c] ?
         (clk ? h_pipe[PIPE-1][c*WIDTH +: WIDTH] : out_l[c*WIDTH +: WIDTH]) : '0;
   end
endmodule
